// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage, single outstanding req/ack/rvalid fetch into a small FIFO feeding decode
module if_fetch_unit #(
  parameter int DEPTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [3:0] TYPE_NONE = 4'd0,
  parameter logic [3:0] TYPE_VALID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        id_redirect,
  input  logic [31:0] id_new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic [3:0]  if_ins_type,
  output logic [3:0]  if_ins_number
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
  logic [1:0] state, state_next;
  logic [31:0] pc, fpc;
  logic drop, empty, push, pop, accept;
  logic [3:0] seq;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_next;
  logic [67:0] fifo [DEPTH];
  assign empty = count == '0;
  assign pop = !empty && !id_stall && !id_redirect;
  assign push = state == WAIT && imem_rvalid && !drop && !id_redirect;
  assign accept = state == REQ && imem_ack;
  assign count_next = id_redirect ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  assign imem_req = state == REQ;
  assign imem_addr = pc;
  assign {if_inst, if_pc4, if_ins_number} = empty ? 68'd0 : fifo[rd_ptr];
  assign if_ins_type = empty ? TYPE_NONE : TYPE_VALID;
  // A request is only issued when a FIFO slot is free, so the response always has room
  always_comb begin
    state_next = state == IDLE ? (!id_redirect && count < FULL ? REQ : IDLE) :
                 state == REQ  ? (imem_ack ? WAIT : id_redirect ? IDLE : REQ) :
                 imem_rvalid   ? (!id_redirect && count_next < FULL ? REQ : IDLE) : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      fpc <= '0;
      drop <= 1'b0;
      seq <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      pc <= id_redirect ? id_new_pc : accept ? pc + 32'd4 : pc;
      if (accept) fpc <= pc;
      // An accepted or in-flight fetch made stale by a redirect must have its response discarded
      if (accept && id_redirect) drop <= 1'b1;
      else if (state == WAIT) drop <= imem_rvalid ? 1'b0 : drop | id_redirect;
      if (push) seq <= seq + 4'd1;
      wr_ptr <= id_redirect ? '0 : wr_ptr + AW'(push);
      rd_ptr <= id_redirect ? '0 : rd_ptr + AW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= {imem_rdata, fpc + 32'd4, seq};
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus with a req/ack/rvalid memory model; a monitor
// pops expected decode-side words from a scoreboard queue whenever the head is consumed.
module tb_if_fetch_unit;
  logic clk, rst, id_stall, id_redirect;
  logic [31:0] id_new_pc;
  logic imem_req, imem_ack, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, if_inst, if_pc4;
  logic [3:0] if_ins_type, if_ins_number;
  int checks = 0, errors = 0;
  int acks_left = 0, ack_delay = 0, rv_delay = 1;
  logic [67:0] exp_q [$];

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .id_stall(id_stall), .id_redirect(id_redirect), .id_new_pc(id_new_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_inst(if_inst), .if_pc4(if_pc4), .if_ins_type(if_ins_type),
    .if_ins_number(if_ins_number)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Memory: word at address a is 0x8C000000 + a; ack after ack_delay cycles, rvalid rv_delay cycles later
  initial begin
    int pend, wcnt;
    logic [31:0] pend_addr;
    pend = 0;
    wcnt = 0;
    pend_addr = 0;
    imem_ack = 0;
    imem_rvalid = 0;
    imem_rdata = 0;
    forever begin
      @(posedge clk);
      #2;
      imem_rvalid = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          imem_rvalid = 1;
          imem_rdata = 32'h8C00_0000 + pend_addr;
        end
      end
      imem_ack = 0;
      if (imem_req && acks_left > 0) begin
        if (wcnt >= ack_delay) begin
          imem_ack = 1;
          wcnt = 0;
          acks_left--;
          pend = rv_delay;
          pend_addr = imem_addr;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  initial begin
    logic [67:0] e;
    forever begin
      @(negedge clk);
      if (!rst && if_ins_type == 4'd1 && !id_stall && !id_redirect) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got inst=%h pc4=%h num=%0d want nothing", if_inst, if_pc4, if_ins_number);
        end else begin
          e = exp_q.pop_front();
          if ({if_inst, if_pc4, if_ins_number} !== e) begin
            errors++;
            $display("FAIL pop got inst=%h pc4=%h num=%0d want inst=%h pc4=%h num=%0d",
                     if_inst, if_pc4, if_ins_number, e[67:36], e[35:4], e[3:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic expect_item(input logic [31:0] inst, input logic [31:0] pc4, input logic [3:0] num);
    exp_q.push_back({inst, pc4, num});
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    @(negedge clk);
    while (!imem_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, imem_req}, 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_inst"}, if_inst, 32'd0);
    chk({tag, "_pc4"}, if_pc4, 32'd0);
    chk({tag, "_type"}, {28'd0, if_ins_type}, 32'd0);
    chk({tag, "_num"}, {28'd0, if_ins_number}, 32'd0);
  endtask

  initial begin
    rst = 1;
    id_stall = 0;
    id_redirect = 0;
    id_new_pc = 0;
    @(negedge clk);
    chk_reset_outputs("reset");
    // Straight-line fetch of three words
    acks_left = 3;
    expect_item(32'h8C00_0000, 32'h4, 4'd0);
    expect_item(32'h8C00_0004, 32'h8, 4'd1);
    expect_item(32'h8C00_0008, 32'hC, 4'd2);
    @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lat_not_yet", {28'd0, if_ins_type}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_first", {28'd0, if_ins_type}, 32'd1);
    drain("t1_drain");
    // Fill FIFO under stall, hold, then release
    @(posedge clk);
    #1;
    id_stall = 1;
    acks_left = 2;
    expect_item(32'h8C00_000C, 32'h10, 4'd3);
    expect_item(32'h8C00_0010, 32'h14, 4'd4);
    repeat (6) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_head", if_inst, 32'h8C00_000C);
    end
    @(posedge clk);
    #1 id_stall = 0;
    drain("t2_drain");
    // Redirect while WAIT with one item held in the FIFO
    wait_req("t3_req0");
    chk("t3_addr0", imem_addr, 32'h14);
    @(posedge clk);
    #1;
    id_stall = 1;
    acks_left = 1;
    rv_delay = 1;
    repeat (2) @(posedge clk);
    wait_req("t3_req1");
    chk("t3_addr1", imem_addr, 32'h18);
    @(posedge clk);
    #1;
    acks_left = 1;
    rv_delay = 3;
    @(negedge clk);
    chk("t3_held", {28'd0, if_ins_type}, 32'd1);
    @(posedge clk);
    #1;
    id_redirect = 1;
    id_new_pc = 32'h100;
    @(posedge clk);
    #1;
    id_redirect = 0;
    id_stall = 0;
    @(negedge clk);
    chk("t3_flushed", {28'd0, if_ins_type}, 32'd0);
    wait_req("t3_req2");
    chk("t3_target", imem_addr, 32'h100);
    @(posedge clk);
    #1;
    acks_left = 1;
    rv_delay = 1;
    expect_item(32'h8C00_0100, 32'h104, 4'd6);
    drain("t3_drain");
    // Redirect coinciding with ack, then with rvalid
    wait_req("t4_req0");
    @(posedge clk);
    #1;
    id_redirect = 1;
    id_new_pc = 32'h200;
    acks_left = 1;
    @(posedge clk);
    #1 id_redirect = 0;
    wait_req("t4_req1");
    chk("t4_addr1", imem_addr, 32'h200);
    @(posedge clk);
    #1 acks_left = 1;
    @(posedge clk);
    #1;
    id_redirect = 1;
    id_new_pc = 32'h300;
    @(posedge clk);
    #1;
    id_redirect = 0;
    acks_left = 1;
    expect_item(32'h8C00_0300, 32'h304, 4'd7);
    drain("t4_drain");
    // Delayed ack: request held stable
    wait_req("t5_req0");
    @(posedge clk);
    #1;
    ack_delay = 3;
    acks_left = 1;
    expect_item(32'h8C00_0304, 32'h308, 4'd8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_req_held", {31'd0, imem_req}, 32'd1);
      chk("t5_addr_held", imem_addr, 32'h304);
    end
    @(negedge clk);
    chk("t5_accepted", {31'd0, imem_req}, 32'd0);
    drain("t5_drain");
    wait_req("t5_req1");
    chk("t5_pc_once", imem_addr, 32'h308);
    // Reset while WAIT; stray rvalid arrives in IDLE afterwards
    @(posedge clk);
    #1;
    ack_delay = 0;
    acks_left = 1;
    rv_delay = 3;
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    wait_req("t6_req");
    chk("t6_reset_pc", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    acks_left = 1;
    rv_delay = 1;
    expect_item(32'h8C00_0000, 32'h4, 4'd0);
    drain("t6_drain");
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
